// File: rtl/div_pkg.sv
// Shared types and helpers for the shared restoring divider: FSM states,
// step-counter width and the quotient clamp test.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Operand widths up to 64 bits are supported by the step counter.
    localparam int DIV_MAX_WIDTH = 64;
    localparam int STEP_W        = $clog2(DIV_MAX_WIDTH + 1);

    // True when q does not fit in qw unsigned bits.
    function automatic logic q_exceeds(input logic [64:0] q, input int unsigned qw);
        return (q >> qw) != 65'd0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after pointer,
// wrapping modulo NUM_CH. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   pointer,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   index,
    output logic              any
);

    always_comb begin
        grant = '0;
        index = '0;
        any   = |req;
        // Scan from the farthest offset down so the nearest requester wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[(int'(pointer) + k) % NUM_CH]) begin
                grant = '0;
                grant[(int'(pointer) + k) % NUM_CH] = 1'b1;
                index = CH_W'((int'(pointer) + k) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/shared_divider_arbiter.sv
// Round-robin shared restoring divider with saturated QWIDTH quotient.
// Optional macro DIV_ROUND_EN adds a ROUND state (round-half-up).
module shared_divider_arbiter
    import div_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int QWIDTH = 12,
    parameter int NUM_CH = 2,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH*WIDTH-1:0] dividend,
    input  logic [NUM_CH*WIDTH-1:0] divisor,
    output logic [NUM_CH-1:0]       done,
    output logic [QWIDTH-1:0]       quotient,
    output logic                    busy,
    output logic [CH_W-1:0]         owner,
    output logic                    div_by_zero,
    output logic                    saturated
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

    state_t              state;
    logic [CH_W-1:0]     pointer;
    logic [STEP_W-1:0]   step;
    logic [WIDTH-1:0]    dvd, dvs, rem, q_int;

    logic [NUM_CH-1:0]   grant;
    logic [CH_W-1:0]     grant_idx;
    logic                grant_any;
    logic [WIDTH-1:0]    sel_dvd, sel_dvs;
    logic [WIDTH:0]      shift;
    logic                ge;
    logic [WIDTH-1:0]    diff;
    logic [WIDTH:0]      q_sel;
    logic                res_sat;
    logic [QWIDTH-1:0]   res_q;

    rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
        .req     (req),
        .pointer (pointer),
        .grant   (grant),
        .index   (grant_idx),
        .any     (grant_any)
    );

    assign sel_dvd = dividend[grant_idx*WIDTH +: WIDTH];
    assign sel_dvs = divisor[grant_idx*WIDTH +: WIDTH];

    always_comb begin
        shift = {rem, dvd[WIDTH-1]};
        ge    = shift >= {1'b0, dvs};
        diff  = shift[WIDTH-1:0] - dvs;
        q_sel = {q_int, ge};
`ifdef DIV_ROUND_EN
        if (state == ROUND)
            q_sel = {1'b0, q_int} + (WIDTH+1)'({rem, 1'b0} >= {1'b0, dvs});
`endif
        res_sat = q_exceeds(65'(q_sel), QWIDTH);
        res_q   = res_sat ? '1 : q_sel[QWIDTH-1:0];
    end

    // Control and result registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pointer     <= '0;
            step        <= '0;
            owner       <= '0;
            busy        <= 1'b0;
            done        <= '0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
            saturated   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant_any) begin
                    owner   <= grant_idx;
                    pointer <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
                    busy    <= 1'b1;
                    step    <= '0;
                    if (sel_dvs == '0) begin
                        quotient    <= '1;
                        div_by_zero <= 1'b1;
                        saturated   <= 1'b0;
                        done        <= grant;
                        state       <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    step <= step + 1'b1;
                    if (step == LAST_STEP) begin
`ifdef DIV_ROUND_EN
                        state <= ROUND;
`else
                        quotient    <= res_q;
                        saturated   <= res_sat;
                        div_by_zero <= 1'b0;
                        done        <= NUM_CH'(1) << owner;
                        state       <= DONE;
`endif
                    end
                end
`ifdef DIV_ROUND_EN
                ROUND: begin
                    quotient    <= res_q;
                    saturated   <= res_sat;
                    div_by_zero <= 1'b0;
                    done        <= NUM_CH'(1) << owner;
                    state       <= DONE;
                end
`endif
                DONE: begin
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operands latched at grant, one restoring step per CALC cycle
    always_ff @(posedge clock) begin
        if (state == IDLE && grant_any) begin
            dvd   <= sel_dvd;
            dvs   <= sel_dvs;
            rem   <= '0;
            q_int <= '0;
        end else if (state == CALC) begin
            rem   <= ge ? diff : shift[WIDTH-1:0];
            q_int <= {q_int[WIDTH-2:0], ge};
            dvd   <= dvd << 1;
        end
    end

endmodule
